// File: rtl/psum_acc_if.sv
// Handshake bundle between a MAC column bottom and its psum_acc: partial-sum beats in, requantized results out.
interface psum_acc_if #(
   parameter int IW = 17,
   parameter int OW = 8
);
   logic          in_valid;
   logic          in_ready;
   logic [IW-1:0] in_data;
   logic          in_first;
   logic          in_last;
   logic [4:0]    shift;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_data;

   modport master (
      output in_valid, in_data, in_first, in_last, shift, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_first, in_last, shift, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/psum_acc.sv
// psum_acc: per-row K-pass accumulator with requantization to OW bits; PSUM_ACC_ROUND_EN selects round-half-up, else floor.
// Latency: 2 cycles from an accepted last-beat to out_valid (stage s1, then output FIFO).
// Backpressure: in_ready drops when FIFO occupancy plus a pending s1 result would reach FIFO_DEPTH.
module psum_acc #(
   parameter int IW         = 17,
   parameter int AW         = 24,
   parameter int OW         = 8,
   parameter int ROWS       = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   psum_acc_if.slave bus,
   output logic      ovf
);
   localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int PW     = $clog2(FIFO_DEPTH);
   localparam int SH_MAX = (AW < 31) ? AW : 31;
   localparam logic signed [AW:0] AMAX = {2'b00, {(AW-1){1'b1}}};
   localparam logic signed [AW:0] AMIN = {2'b11, {(AW-1){1'b0}}};
   localparam logic signed [AW:0] QMAX = {{(AW-OW+2){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [AW:0] QMIN = {{(AW-OW+2){1'b1}}, {(OW-1){1'b0}}};

   logic [RW-1:0]        row;
   logic signed [AW-1:0] acc [ROWS];
   logic                 s1_valid;
   logic [OW-1:0]        s1_data;
   logic [OW-1:0]        mem [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [PW:0]          count;

   logic                 accept;
   logic                 pop;
   logic signed [AW:0]   psum_x;
   logic signed [AW:0]   sum_raw;
   logic signed [AW:0]   sum_sat;
   logic signed [AW:0]   rnd;
   logic signed [AW:0]   q_wide;
   logic [4:0]           sh_eff;
   logic                 acc_sat;
   logic                 q_clamp;
   logic [OW-1:0]        q;

   assign bus.in_ready  = (32'(count) + 32'(s1_valid)) < FIFO_DEPTH;
   assign bus.out_valid = (count != '0);
   assign bus.out_data  = mem[rd_ptr];
   assign accept        = bus.in_valid && bus.in_ready;
   assign pop           = bus.out_valid && bus.out_ready;

   always_comb begin
      psum_x  = (AW+1)'(signed'(bus.in_data));
      sum_raw = bus.in_first ? psum_x : (AW+1)'(acc[row]) + psum_x;

      acc_sat = 1'b0;
      sum_sat = sum_raw;
      if (sum_raw > AMAX) begin
         sum_sat = AMAX;
         acc_sat = 1'b1;
      end else if (sum_raw < AMIN) begin
         sum_sat = AMIN;
         acc_sat = 1'b1;
      end

      // Shifts past AW already yield 0 or -1, so capping keeps the rounding bit inside AW+1 bits.
      sh_eff = (32'(bus.shift) > SH_MAX) ? 5'(SH_MAX) : bus.shift;
      rnd    = '0;
`ifdef PSUM_ACC_ROUND_EN
      if (sh_eff != 5'd0) rnd[sh_eff - 5'd1] = 1'b1;
`endif
      q_wide = (sum_sat + rnd) >>> sh_eff;

      q_clamp = 1'b0;
      q       = q_wide[OW-1:0];
      if (q_wide > QMAX) begin
         q       = QMAX[OW-1:0];
         q_clamp = 1'b1;
      end else if (q_wide < QMIN) begin
         q       = QMIN[OW-1:0];
         q_clamp = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row      <= '0;
         s1_valid <= 1'b0;
         s1_data  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         ovf      <= 1'b0;
         for (int i = 0; i < ROWS; i++) acc[i] <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         s1_valid <= accept && bus.in_last;
         if (accept) begin
            acc[row] <= sum_sat[AW-1:0];
            row      <= (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);
            if (bus.in_last) s1_data <= q;
            if (acc_sat || (bus.in_last && q_clamp)) ovf <= 1'b1;
         end
         // in_ready guarantees room, so s1 always lands in the FIFO the next cycle.
         if (s1_valid) begin
            mem[wr_ptr] <= s1_data;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + (PW+1)'(s1_valid) - (PW+1)'(pop);
      end
   end
endmodule

// File: tb/tb_psum_acc.sv
// Bench for psum_acc (ROWS=4): vector table, directed corner sequences, and random traffic against a reference model.
module tb_psum_acc;
   localparam int ROWS = 4;
   localparam longint AMAX = 64'sd8388607;
   localparam longint AMIN = -64'sd8388608;
`ifdef PSUM_ACC_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ovf;

   psum_acc_if #(.IW(17), .OW(8)) bus ();

   psum_acc #(.IW(17), .AW(24), .OW(8), .ROWS(ROWS), .FIFO_DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .ovf (ovf)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errs   = 0;

   // Reference model: plain integer arithmetic on the accumulation/requant rules.
   longint m_acc [ROWS];
   int     m_row = 0;
   bit     m_ovf = 1'b0;
   int     exp_q [$];
   bit     use_model = 1'b0;

   typedef struct {
      int d; bit f; bit l; int sh; int e_tr; int e_rn; int ovf_chk;
   } vec_t;
   vec_t tbl [10];

   task automatic check(string name, int act, int exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic note_fail(string name, string what);
      n_checks++;
      n_errs++;
      $display("FAIL %s: %s", name, what);
   endtask

   function automatic int model_beat(int d, bit first, bit last, int sh);
      longint s;
      longint r;
      s = first ? longint'(d) : m_acc[m_row] + longint'(d);
      if (s > AMAX) begin s = AMAX; m_ovf = 1'b1; end
      else if (s < AMIN) begin s = AMIN; m_ovf = 1'b1; end
      m_acc[m_row] = s;
      m_row = (m_row + 1) % ROWS;
      r = 0;
      if (last) begin
         r = s;
         if (RND && sh > 0) r = r + (64'sd1 <<< (sh - 1));
         r = r >>> sh;
         if (r > 127) begin r = 127; m_ovf = 1'b1; end
         else if (r < -128) begin r = -128; m_ovf = 1'b1; end
      end
      return int'(r);
   endfunction

   always @(negedge clk) begin : mon
      int q;
      if (!rst) begin
         if (bus.in_valid && bus.in_ready) begin
            q = model_beat(int'($signed(bus.in_data)), bus.in_first, bus.in_last, int'(bus.shift));
            if (bus.in_last && use_model) exp_q.push_back(q);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0)
               note_fail("out_unexpected", $sformatf("got %0d, expected no output", int'($signed(bus.out_data))));
            else
               check("out_data", int'($signed(bus.out_data)), exp_q.pop_front());
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < ROWS; i++) m_acc[i] = 0;
      m_row = 0;
      m_ovf = 1'b0;
      exp_q.delete();
   endtask

   task automatic send(int d, bit f, bit l, int sh);
      bit ok;
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 17'(d);
      bus.in_first = f;
      bus.in_last  = l;
      bus.shift    = 5'(sh);
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (bus.in_ready) begin ok = 1'b1; break; end
         @(posedge clk);
         #1;
      end
      if (ok) begin
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      if (!ok) note_fail("send_timeout", "in_ready stayed low for 200 cycles, required high");
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      for (int n = 0; n < 300; n++) begin
         if (exp_q.size() == 0 && !bus.out_valid) begin done = 1'b1; break; end
         @(negedge clk);
      end
      if (!done) note_fail("drain_timeout", $sformatf("%0d results still pending, required 0", exp_q.size()));
      @(posedge clk);
      #1;
   endtask

   initial begin
      int acc_cnt;
      bit rnd_done;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_first  = 1'b0;
      bus.in_last   = 1'b0;
      bus.shift     = '0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < ROWS; i++) m_acc[i] = 0;

      // Reset state
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", int'(bus.in_ready), 1);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_out_data", int'(bus.out_data), 0);
      check("rst_ovf", int'(ovf), 0);
      @(posedge clk);
      #1;

      // Two-cycle latency into an empty FIFO with out_ready high
      use_model = 1'b1;
      bus.out_ready = 1'b1;
      send(9, 1'b1, 1'b1, 0);
      @(negedge clk);
      check("lat_cycle1_out_valid", int'(bus.out_valid), 0);
      @(negedge clk);
      check("lat_cycle2_out_valid", int'(bus.out_valid), 1);
      check("lat_cycle2_out_data", int'($signed(bus.out_data)), 9);
      drain();

      // Vector table: two-pass tile, then single-pass clamps
      do_reset();
      use_model = 1'b0;
      tbl[0] = '{10,     1, 0, 2, 0,    0,    -1};
      tbl[1] = '{20,     1, 0, 2, 0,    0,    -1};
      tbl[2] = '{30,     1, 0, 2, 0,    0,    -1};
      tbl[3] = '{40,     1, 0, 2, 0,    0,    -1};
      tbl[4] = '{5,      0, 1, 2, 3,    4,    -1};
      tbl[5] = '{-25,    0, 1, 2, -2,   -1,   -1};
      tbl[6] = '{100,    0, 1, 2, 32,   33,   -1};
      tbl[7] = '{-300,   0, 1, 2, -65,  -65,  0};
      tbl[8] = '{65535,  1, 1, 0, 127,  127,  1};
      tbl[9] = '{-65536, 1, 1, 0, -128, -128, 1};
      for (int i = 0; i < 10; i++) begin
         if (tbl[i].l) exp_q.push_back(RND ? tbl[i].e_rn : tbl[i].e_tr);
         send(tbl[i].d, tbl[i].f, tbl[i].l, tbl[i].sh);
         if (tbl[i].ovf_chk >= 0) begin
            drain();
            check($sformatf("tbl%0d_ovf", i), int'(ovf), tbl[i].ovf_chk);
         end
      end

      // Accumulator saturation over 200 passes
      do_reset();
      for (int p = 0; p < 200; p++) begin
         if (p == 199) for (int r = 0; r < ROWS; r++) exp_q.push_back(127);
         for (int r = 0; r < ROWS; r++) send(65535, p == 0, p == 199, 16);
      end
      drain();
      check("sat_ovf", int'(ovf), 1);

      // Full FIFO: exactly four last-beats accepted, then recovery in order
      do_reset();
      use_model = 1'b1;
      bus.out_ready = 1'b0;
      acc_cnt = 0;
      for (int c = 0; c < 10; c++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 17'(acc_cnt + 1);
         bus.in_first = 1'b1;
         bus.in_last  = 1'b1;
         bus.shift    = 5'd0;
         @(negedge clk);
         if (bus.in_ready) acc_cnt++;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      check("full_accepts", acc_cnt, 4);
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("full_ready_before_pop", int'(bus.in_ready), 0);
      @(negedge clk);
      check("full_ready_after_pop", int'(bus.in_ready), 1);
      @(posedge clk);
      #1;
      for (int v = acc_cnt + 1; v <= 8; v++) send(v, 1'b1, 1'b1, 0);
      drain();

      // Reset mid-pass with results queued and ovf set
      do_reset();
      bus.out_ready = 1'b0;
      send(65535, 1'b1, 1'b1, 0);
      send(65535, 1'b1, 1'b1, 0);
      send(3, 1'b1, 1'b0, 0);
      repeat (2) @(posedge clk);
      #1;
      check("mid_ovf_before_rst", int'(ovf), 1);
      do_reset();
      @(negedge clk);
      check("mid_rst_out_valid", int'(bus.out_valid), 0);
      check("mid_rst_ovf", int'(ovf), 0);
      check("mid_rst_in_ready", int'(bus.in_ready), 1);
      @(posedge clk);
      #1;
      use_model = 1'b0;
      bus.out_ready = 1'b1;
      exp_q.push_back(7);
      send(7, 1'b0, 1'b1, 0);
      drain();

      // Random traffic with random consumer stalls
      do_reset();
      use_model = 1'b1;
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               send(int'($urandom_range(0, 131071)) - 65536, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 2) == 0, int'($urandom_range(0, 20)));
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               bus.out_ready = ($urandom_range(0, 2) != 0);
               @(posedge clk);
               #1;
            end
         end
      join
      drain();
      check("rand_ovf", int'(ovf), int'(m_ovf));

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, required finish within 2000000 time units");
      $fatal(1);
   end
endmodule
